fifo_pkt_framer: RTL and testbench



---
 rtl/fifo_pkt_pkg.sv | 23 ++
 rtl/fifo_pkt_framer_out_reg.sv | 41 ++++
 rtl/fifo_pkt_framer.sv | 158 +++++++++++++++
 tb/tb_fifo_pkt_framer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkt_pkg.sv
// Shared types and width helpers for the FIFO packet framer.
package fifo_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PAD,
        CHECKSUM
    } state_t;

    localparam int FRAME_CNT_W = 16;

    // Counters must be able to hold the terminal value itself, hence n+1.
    function automatic int word_cnt_w(input int pkt_len);
        return $clog2(pkt_len + 1);
    endfunction

    function automatic int starve_cnt_w(input int idle_timeout);
        return $clog2(idle_timeout + 1);
    endfunction

endpackage

// File: rtl/fifo_pkt_framer_out_reg.sv
// Single-entry output register for the framer stream: a data word plus sof/eof flags.
// Handshake: a beat transfers on a clk edge where out_valid && out_ready; while
// out_valid && !out_ready every out_* holds, otherwise the register reloads each cycle.
module pkt_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_valid,
    input  logic [DATA_WIDTH-1:0] beat_data,
    input  logic                  beat_sof,
    input  logic                  beat_eof,
    input  logic                  out_ready,
    output logic                  load,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eof
);

    logic [DATA_WIDTH+1:0] beat_q;

    assign load = !out_valid || out_ready;

    // A load without a new beat empties the register; flags and data follow the
    // upstream defaults (all zero) in that case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            beat_q    <= '0;
        end else if (load) begin
            out_valid <= beat_valid;
            beat_q    <= {beat_sof, beat_eof, beat_data};
        end
    end

    assign out_data = beat_q[DATA_WIDTH-1:0];
    assign out_eof  = beat_q[DATA_WIDTH];
    assign out_sof  = beat_q[DATA_WIDTH+1];

endmodule

// File: rtl/fifo_pkt_framer.sv
// Pops payload words from a FIFO and emits header / PKT_LEN payload / XOR checksum
// frames; a frame starved for IDLE_TIMEOUT cycles is completed with PAD_VALUE words.
module fifo_pkt_framer
    import fifo_pkt_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    PKT_LEN      = 4,
    parameter int                    IDLE_TIMEOUT = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_valid,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic                   pad_pulse,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int WCNT_W = word_cnt_w(PKT_LEN);
    localparam int SCNT_W = starve_cnt_w(IDLE_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PKT_LEN - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(PKT_LEN);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(IDLE_TIMEOUT);

    state_t                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    seq_q, seq_d;
    logic [DATA_WIDTH-1:0]    chk_q, chk_d;
    logic [WCNT_W-1:0]        wcnt_q, wcnt_d, wcnt_inc;
    logic [SCNT_W-1:0]        scnt_q, scnt_d, scnt_inc;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                     pad_pulse_d;

    logic                     load;
    logic                     beat_valid;
    logic [DATA_WIDTH-1:0]    beat_data;
    logic                     beat_sof;
    logic                     beat_eof;

    assign wcnt_inc = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
    assign scnt_inc = (scnt_q == SCNT_MAX) ? scnt_q : scnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            chk_q       <= '0;
            wcnt_q      <= '0;
            scnt_q      <= '0;
            frame_cnt_q <= '0;
            pad_pulse   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            chk_q       <= chk_d;
            wcnt_q      <= wcnt_d;
            scnt_q      <= scnt_d;
            frame_cnt_q <= frame_cnt_d;
            pad_pulse   <= pad_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        chk_d       = chk_q;
        wcnt_d      = wcnt_q;
        scnt_d      = scnt_q;
        frame_cnt_d = frame_cnt_q;
        pad_pulse_d = 1'b0;
        rd_en       = 1'b0;
        beat_valid  = 1'b0;
        beat_data   = '0;
        beat_sof    = 1'b0;
        beat_eof    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_valid) state_d = HEADER;
            end
            HEADER: begin
                if (load) begin
                    beat_valid = 1'b1;
                    beat_data  = seq_q;
                    beat_sof   = 1'b1;
                    chk_d      = '0;
                    wcnt_d     = '0;
                    scnt_d     = '0;
                    state_d    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // A pop takes priority over the timeout that would fire this cycle.
                if (load && rd_valid) begin
                    rd_en      = 1'b1;
                    beat_valid = 1'b1;
                    beat_data  = rd_data;
                    chk_d      = chk_q ^ rd_data;
                    wcnt_d     = wcnt_inc;
                    scnt_d     = '0;
                    if (wcnt_q == WCNT_LAST) state_d = CHECKSUM;
                end else if (load) begin
                    scnt_d = scnt_inc;
                    if (scnt_q == SCNT_LAST) begin
                        state_d     = PAD;
                        pad_pulse_d = 1'b1;
                    end
                end
            end
            PAD: begin
                if (load) begin
                    beat_valid = 1'b1;
                    beat_data  = PAD_VALUE;
                    chk_d      = chk_q ^ PAD_VALUE;
                    wcnt_d     = wcnt_inc;
                    if (wcnt_q == WCNT_LAST) state_d = CHECKSUM;
                end
            end
            CHECKSUM: begin
                if (load) begin
                    beat_valid  = 1'b1;
                    beat_data   = chk_q;
                    beat_eof    = 1'b1;
                    seq_d       = seq_q + 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    pkt_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_valid(beat_valid),
        .beat_data (beat_data),
        .beat_sof  (beat_sof),
        .beat_eof  (beat_eof),
        .out_ready (out_ready),
        .load      (load),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Bench for fifo_pkt_framer: FIFO model on the read side, frame-level scoreboard on the output.
module tb_fifo_pkt_framer;

    localparam int         PKT_LEN = 4;
    localparam logic [7:0] PAD     = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_valid = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        out_ready = 1'b0;
    logic        rd_en, out_valid, out_sof, out_eof, pad_pulse;
    logic [7:0]  out_data;
    logic [15:0] frame_cnt;

    fifo_pkt_framer #(
        .DATA_WIDTH  (8),
        .PKT_LEN     (PKT_LEN),
        .IDLE_TIMEOUT(16),
        .PAD_VALUE   (PAD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_en    (rd_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sof  (out_sof),
        .out_eof  (out_eof),
        .pad_pulse(pad_pulse),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model: the pop decision is taken from stable mid-cycle values, and the
    // head word is refreshed shortly after each edge.
    logic [7:0] fifo_q[$];
    int         pops = 0;
    logic       do_pop = 1'b0;

    always @(negedge clk) do_pop = rd_en && rd_valid;

    always @(posedge clk) begin
        #2;
        if (do_pop && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        rd_valid = (fifo_q.size() != 0);
        rd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    // Frame model: header = seq, payload = popped words in order (PAD once none is
    // pending), checksum = XOR of the payload; frame_cnt counts checksum beats issued.
    logic [7:0] exp_q[$];
    logic [7:0] log_d[$];
    int         log_cyc[$];
    logic [7:0] hdr_q[$];
    int         pos = 0;
    logic [7:0] m_seq = 8'h00;
    logic [7:0] m_chk = 8'h00;
    int         m_done = 0;
    int         m_loaded = 0;
    int         frame_pads = 0;
    int         frame_pulses = 0;
    int         total_pulses = 0;
    int         cyc = 0;
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_sof = 1'b0, prev_eof = 1'b0;
    logic       prev_pulse = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic model_reset();
        exp_q.delete();
        log_d.delete();
        log_cyc.delete();
        hdr_q.delete();
        pos          = 0;
        m_seq        = 8'h00;
        m_done       = 0;
        m_loaded     = 0;
        frame_pulses = 0;
    endtask

    task automatic accept_beat();
        logic [7:0] w;
        log_d.push_back(out_data);
        log_cyc.push_back(cyc);
        if (pos == 0) begin
            check("hdr_sof", out_sof, 1'b1);
            check("hdr_eof", out_eof, 1'b0);
            check("hdr_seq", out_data, m_seq);
            hdr_q.push_back(out_data);
            m_chk      = 8'h00;
            frame_pads = 0;
            pos        = 1;
        end else if (pos <= PKT_LEN) begin
            check("pay_sof", out_sof, 1'b0);
            check("pay_eof", out_eof, 1'b0);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
            end else begin
                w = PAD;
                frame_pads++;
            end
            check("pay_data", out_data, w);
            m_chk = m_chk ^ w;
            pos++;
        end else begin
            check("chk_sof", out_sof, 1'b0);
            check("chk_eof", out_eof, 1'b1);
            check("chk_data", out_data, m_chk);
            check("pulses_per_frame", frame_pulses, (frame_pads > 0) ? 1 : 0);
            frame_pulses = 0;
            m_seq++;
            m_done++;
            pos = 0;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_pulse = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
                check("hold_flags", {out_sof, out_eof}, {prev_sof, prev_eof});
            end
            if (out_valid && !out_ready) check("rd_en_backpressure", rd_en, 1'b0);
            if (out_valid && out_eof && (!prev_valid || prev_ready)) m_loaded++;
            check("frame_cnt", frame_cnt, m_loaded[15:0]);
            if (pad_pulse) begin
                check("pad_pulse_width", prev_pulse, 1'b0);
                frame_pulses++;
                total_pulses++;
            end
            if (out_valid && out_ready) accept_beat();
            if (rd_en && rd_valid) exp_q.push_back(rd_data);
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_sof   = out_sof;
            prev_eof   = out_eof;
            prev_pulse = pad_pulse;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget, input bit toggle);
        int n = 0;
        while (m_done < target && n < budget) begin
            step();
            if (toggle) out_ready = ~out_ready;
            n++;
        end
        if (m_done < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: frames done %0d, required %0d", m_done, target);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic wait_pop(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!do_pop && n < budget);
        if (!do_pop) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_timeout: no pop within %0d cycles", budget);
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3,
                               input logic [7:0] e4, input logic [7:0] e5);
        logic [7:0] e[6];
        e = '{e0, e1, e2, e3, e4, e5};
        check({name, "_beats"}, log_d.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_d.size()) check({name, "_beat"}, log_d[i], e[i]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fifo_q.delete();
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int p0, t0;
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_flags", {out_sof, out_eof, pad_pulse, rd_en}, 4'b0000);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // Full frame, no backpressure, plus 2-cycle header latency
        log_d.delete();
        log_cyc.delete();
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
        step();
        check("latency_1cyc_valid", out_valid, 1'b0);
        step();
        check("latency_hdr", {out_valid, out_sof, out_data}, {2'b11, 8'h00});
        wait_done(1, 50, 1'b0);
        check_frame("full", 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        if (log_cyc.size() == 6) check("full_consecutive", log_cyc[5] - log_cyc[0], 5);
        check("full_frame_cnt", frame_cnt, 16'd1);

        // Backpressure: ready toggles every cycle
        log_d.delete();
        p0 = pops;
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
        wait_done(2, 80, 1'b1);
        check_frame("bp", 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        check("bp_pops", pops - p0, 4);

        // Starve and pad
        log_d.delete();
        t0 = total_pulses;
        fifo_q.push_back(8'hA5); fifo_q.push_back(8'h5A);
        wait_done(3, 80, 1'b0);
        check_frame("pad", 8'h02, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'hFF);
        check("pad_pulses", total_pulses - t0, 1);

        // Pop arriving on the exact timeout cycle wins, every time
        log_d.delete();
        t0 = total_pulses;
        fifo_q.push_back(8'h01);
        wait_pop(20);
        for (int k = 2; k <= 4; k++) begin
            repeat (15) step();
            fifo_q.push_back(8'(k));
            wait_pop(5);
        end
        wait_done(4, 40, 1'b0);
        check_frame("edge", 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        check("edge_pulses", total_pulses - t0, 0);

        // Sequence wrap over 258 back-to-back frames
        do_reset();
        begin
            int pushed = 0;
            int n = 0;
            while (m_done < 258 && n < 4000) begin
                step();
                n++;
                if (fifo_q.size() < 6 && pushed < 258 * PKT_LEN) begin
                    fifo_q.push_back(8'(pushed * 7 + 3));
                    pushed++;
                end
            end
        end
        wait_done(258, 10, 1'b0);
        check("wrap_hdr_count", hdr_q.size(), 258);
        if (hdr_q.size() == 258) begin
            check("wrap_hdr_255", hdr_q[255], 8'hFF);
            check("wrap_hdr_256", hdr_q[256], 8'h00);
            check("wrap_hdr_257", hdr_q[257], 8'h01);
        end
        check("wrap_frame_cnt", frame_cnt, 16'd258);

        // Reset mid-frame after the 2nd payload beat
        fifo_q.push_back(8'h10); fifo_q.push_back(8'h20);
        fifo_q.push_back(8'h30); fifo_q.push_back(8'h40);
        begin
            int n = 0;
            while (pos < 3 && n < 50) begin
                step();
                n++;
            end
            check("mid_reached", pos, 3);
        end
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", out_valid, 1'b0);
        check("mid_async_frame_cnt", frame_cnt, 16'd0);
        fifo_q.delete();
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("mid_frame_cnt", frame_cnt, 16'd0);
        fifo_q.push_back(8'h0F); fifo_q.push_back(8'hF0);
        fifo_q.push_back(8'h3C); fifo_q.push_back(8'hC3);
        wait_done(1, 50, 1'b0);
        check_frame("after_rst", 8'h00, 8'h0F, 8'hF0, 8'h3C, 8'hC3, 8'h00);

        // Empty FIFO idle
        t0 = total_pulses;
        repeat (100) begin
            step();
            check("idle_quiet", {out_valid, rd_en, pad_pulse}, 3'b000);
        end
        check("idle_pulses", total_pulses - t0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
